logic_unit_pipe: RTL and testbench

Parametrised successor to the team's two-input combinational gates. Applies one of eight selectable bitwise operations to two WIDTH-bit operands through a 2-stage valid/ready pipeline. Also provides a running OR accumulator and a completed-transaction counter. Sits between a stimulus source and a result sink, with backpressure from both sides.

---
 rtl/logic_unit_pipe.sv | 126 ++++++++++++
 tb/tb_logic_unit_pipe.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready bitwise logic unit with a running OR accumulator
// and a completed-transfer counter.
module logic_unit_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       OP,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y,
    output logic             Z,
    output logic             ONES,
    output logic [CNT_W-1:0] txn_count
);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NAND = 3'b011;
    localparam logic [2:0] OP_NOR  = 3'b100;
    localparam logic [2:0] OP_XNOR = 3'b101;
    localparam logic [2:0] OP_NOTA = 3'b110;
    localparam logic [2:0] OP_ACC  = 3'b111;

    logic             rst_done;
    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [2:0]       s1_op;
    logic             s2_valid;
    logic [WIDTH-1:0] acc;

    logic             out_xfer;
    logic             s2_load;
    logic             in_xfer;
    logic             acc_move;
    logic [WIDTH-1:0] acc_base;
    logic [WIDTH-1:0] result;

    assign out_xfer  = s2_valid & out_ready;
    assign s2_load   = s1_valid & (~s2_valid | out_xfer);
    // rst_done holds off the first input until one clock after reset release
    assign in_ready  = rst_done & (~s1_valid | s2_load);
    assign in_xfer   = in_valid & in_ready;
    assign out_valid = s2_valid;
    assign acc_move  = s2_load & (s1_op == OP_ACC);
    assign acc_base  = acc_clr ? '0 : acc;

    always_comb begin
        result = '0;
        case (s1_op)
            OP_AND:  result = s1_a & s1_b;
            OP_OR:   result = s1_a | s1_b;
            OP_XOR:  result = s1_a ^ s1_b;
            OP_NAND: result = ~(s1_a & s1_b);
            OP_NOR:  result = ~(s1_a | s1_b);
            OP_XNOR: result = ~(s1_a ^ s1_b);
            OP_NOTA: result = ~s1_a;
            OP_ACC:  result = acc_base | s1_a;
            default: result = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_done <= 1'b0;
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= '0;
        end else begin
            rst_done <= 1'b1;
            if (in_xfer) begin
                s1_valid <= 1'b1;
                s1_a     <= A;
                s1_b     <= B;
                s1_op    <= OP;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            Y        <= '0;
            Z        <= 1'b0;
            ONES     <= 1'b0;
        end else if (s2_load) begin
            s2_valid <= 1'b1;
            Y        <= result;
            Z        <= (result == '0);
            ONES     <= (result == {WIDTH{1'b1}});
        end else if (out_xfer) begin
            s2_valid <= 1'b0;
        end
    end

    // Clear wins over a concurrent ACC beat: acc_base already folds it in
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (acc_move) begin
            acc <= acc_base | s1_a;
        end else if (acc_clr) begin
            acc <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txn_count <= '0;
        end else if (out_xfer) begin
            txn_count <= txn_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe at WIDTH=4, CNT_W=4: ops, streaming,
// stall, accumulator and mid-operation reset.
module tb_logic_unit_pipe;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] A;
    logic [3:0] B;
    logic [2:0] OP;
    logic       acc_clr;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] Y;
    logic       Z;
    logic       ONES;
    logic [3:0] txn_count;

    int n_checks = 0;
    int n_errors = 0;
    int exp_txn  = 0;

    logic_unit_pipe #(.WIDTH(4), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .OP        (OP),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Y         (Y),
        .Z         (Z),
        .ONES      (ONES),
        .txn_count (txn_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated beat with out_ready high; result checked two edges later
    task automatic send(input string tag, input logic [2:0] op, input logic [3:0] a,
                        input logic [3:0] b, input logic clr, input logic [3:0] exp_y);
        in_valid = 1'b1;
        OP = op;
        A  = a;
        B  = b;
        #1;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        acc_clr  = clr;
        check({tag, "_lat1"}, 32'(out_valid), 32'd0);
        tick();
        acc_clr = 1'b0;
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_y"}, 32'(Y), 32'(exp_y));
        check({tag, "_z"}, 32'(Z), 32'(exp_y == 4'b0000));
        check({tag, "_ones"}, 32'(ONES), 32'(exp_y == 4'b1111));
        exp_txn++;
    endtask

    initial begin
        logic [3:0] exp_ops [8];
        logic [3:0] exp_b2b;
        int got;
        int first_seen;
        int last_seen;

        exp_ops = '{4'b1000, 4'b1110, 4'b0110, 4'b0111, 4'b0001, 4'b1001, 4'b0011, 4'b0000};

        rst = 1'b1;
        in_valid = 1'b0;
        A = '0;
        B = '0;
        OP = '0;
        acc_clr = 1'b0;
        out_ready = 1'b1;
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_y", 32'(Y), 32'd0);
        check("rst_z", 32'(Z), 32'd0);
        check("rst_ones", 32'(ONES), 32'd0);
        check("rst_txn", 32'(txn_count), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // back-to-back stream, XOR with all ones
        got = 0;
        first_seen = -1;
        last_seen = -1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            in_valid = (cyc < 16);
            A  = 4'(cyc);
            B  = 4'hF;
            OP = 3'b010;
            tick();
            if (out_valid) begin
                exp_b2b = 4'(got) ^ 4'hF;
                check("b2b_y", 32'(Y), 32'(exp_b2b));
                if (first_seen < 0) first_seen = cyc;
                last_seen = cyc;
                got++;
            end
            if (cyc == 10) check("b2b_txn_mid", 32'(txn_count), 32'd9);
        end
        in_valid = 1'b0;
        exp_txn += 16;
        check("b2b_count", 32'(got), 32'd16);
        check("b2b_first", 32'(first_seen), 32'd1);
        check("b2b_last", 32'(last_seen), 32'd16);
        check("b2b_txn_wrap", 32'(txn_count), 32'(exp_txn % 16));

        // every non-ACC op on A=1100 B=1010, plus an all-zero AND result
        for (int i = 0; i < 7; i++) begin
            send("op", 3'(i), 4'b1100, 4'b1010, 1'b0, exp_ops[i]);
        end
        send("op_zero", 3'b000, 4'b1111, 4'b0000, 1'b0, exp_ops[7]);
        tick();
        check("op_txn", 32'(txn_count), 32'(exp_txn % 16));

        // accumulator: build up, clear-with-beat, then clear alone
        send("acc1", 3'b111, 4'b0001, 4'b0000, 1'b0, 4'b0001);
        send("acc2", 3'b111, 4'b0100, 4'b0000, 1'b0, 4'b0101);
        send("acc3", 3'b111, 4'b0000, 4'b0000, 1'b0, 4'b0101);
        send("acc_clr_beat", 3'b111, 4'b0010, 4'b0000, 1'b1, 4'b0010);
        send("acc_read", 3'b111, 4'b0000, 4'b0000, 1'b0, 4'b0010);
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        send("acc_after_clr", 3'b111, 4'b0000, 4'b0000, 1'b0, 4'b0000);
        tick();
        check("acc_txn", 32'(txn_count), 32'(exp_txn % 16));

        // stall: two beats get held, third waits on in_ready
        out_ready = 1'b0;
        in_valid = 1'b1;
        OP = 3'b001;
        B = 4'b0000;
        A = 4'b0001;
        tick();
        A = 4'b0010;
        #1;
        check("stall_ready1", 32'(in_ready), 32'd1);
        tick();
        A = 4'b0100;
        #1;
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_y0", 32'(Y), 32'd1);
        check("stall_ready_low", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_hold_y", 32'(Y), 32'd1);
            check("stall_hold_valid", 32'(out_valid), 32'd1);
            check("stall_hold_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        check("stall_release_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("stall_y1", 32'(Y), 32'b0010);
        check("stall_y1_valid", 32'(out_valid), 32'd1);
        tick();
        check("stall_y2", 32'(Y), 32'b0100);
        check("stall_y2_valid", 32'(out_valid), 32'd1);
        tick();
        check("stall_drained", 32'(out_valid), 32'd0);
        exp_txn += 3;
        check("stall_txn", 32'(txn_count), 32'(exp_txn % 16));

        // reset with both stages full; acc loaded by the first beat
        out_ready = 1'b0;
        in_valid = 1'b1;
        OP = 3'b111;
        A = 4'b1000;
        tick();
        OP = 3'b000;
        A = 4'b0001;
        B = 4'b0001;
        tick();
        in_valid = 1'b0;
        check("mid_valid", 32'(out_valid), 32'd1);
        check("mid_y", 32'(Y), 32'b1000);
        check("mid_txn", 32'(txn_count), 32'(exp_txn % 16));
        #1 rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_y", 32'(Y), 32'd0);
        check("mid_rst_txn", 32'(txn_count), 32'd0);
        out_ready = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("mid_rel_ready", 32'(in_ready), 32'd1);
        check("mid_rel_valid", 32'(out_valid), 32'd0);
        check("mid_rel_txn", 32'(txn_count), 32'd0);
        exp_txn = 0;
        send("post_rst_and", 3'b000, 4'b1111, 4'b1111, 1'b0, 4'b1111);
        send("post_rst_acc", 3'b111, 4'b0000, 4'b0000, 1'b0, 4'b0000);
        tick();
        check("post_rst_txn", 32'(txn_count), 32'(exp_txn % 16));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
